// File: rtl/vram_pkg.sv
// vram_pkg: shared defaults and types for the VRAM arbiter slice.
//   DEF_ADDR_W / DEF_DATA_W : default VRAM word address / data widths
//   DEF_STARVE_MAX          : default forced-CPU-slot threshold (guard builds)
//   STARVE_W                : starvation counter width
//   owner_t                 : owner of the RAM access whose read data returns next cycle
package vram_pkg;

    localparam int unsigned DEF_ADDR_W     = 13;
    localparam int unsigned DEF_DATA_W     = 16;
    localparam int unsigned DEF_STARVE_MAX = 15;
    localparam int unsigned STARVE_W       = 8;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_VGA  = 2'd1,
        OWN_CPU  = 2'd2
    } owner_t;

endpackage

// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if: bundles the VGA fetch, CPU access and VRAM macro signals.
//   slave  : arbiter side (takes requests and RAM read data, drives grants,
//            returns and the RAM command)
//   master : environment side (VGA fetcher, CPU window and RAM macro)
interface vram_arbiter_if
    import vram_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
);

    // VGA fetch path
    logic              vga_req;
    logic [ADDR_W-1:0] vga_addr;
    logic              vga_gnt;
    logic              vga_rvalid;
    logic [DATA_W-1:0] vga_rdata;

    // CPU load/store path
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;

    // VRAM macro port
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  vga_req, vga_addr,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  ram_rdata,
        output vga_gnt, vga_rvalid, vga_rdata,
        output cpu_ack, cpu_rdata,
        output ram_en, ram_we, ram_addr, ram_wdata
    );

    modport master (
        output vga_req, vga_addr,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output ram_rdata,
        input  vga_gnt, vga_rvalid, vga_rdata,
        input  cpu_ack, cpu_rdata,
        input  ram_en, ram_we, ram_addr, ram_wdata
    );

endinterface

// File: rtl/vram_starve_guard.sv
// vram_starve_guard: counts consecutive cycles a ready CPU request is denied
// and raises a force flag once STARVE_MAX denials have accumulated, so the
// next cycle goes to the CPU even against a VGA request.
//   clk, rst     : clock, asynchronous active-high reset
//   cpu_req      : CPU request level
//   cpu_busy     : CPU re-grant blocked this cycle (ack cycle)
//   cpu_gnt      : CPU granted this cycle
//   force_cpu_c  : combinational, CPU slot is due this cycle
module vram_starve_guard
    import vram_pkg::*;
#(
    parameter int unsigned STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic clk,
    input  logic rst,
    input  logic cpu_req,
    input  logic cpu_busy,
    input  logic cpu_gnt,
    output logic force_cpu_c
);

    localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_MAX);

    logic [STARVE_W-1:0] starve_cnt;

    // Qualified by cpu_req so a cancelled request cannot steal a VGA slot.
    assign force_cpu_c = cpu_req & (starve_cnt == LIMIT);

    // Denial counter: clears on service or withdrawal, saturates at LIMIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (cpu_gnt || !cpu_req) begin
            starve_cnt <= '0;
        end else if (!cpu_busy && (starve_cnt != LIMIT)) begin
            starve_cnt <= starve_cnt + STARVE_W'(1);
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port synchronous VRAM between the VGA
// scan-out fetcher (fixed priority) and the CPU load/store window.
// Optional build macro VRAM_STARVE_GUARD_EN enables a forced CPU slot after
// STARVE_MAX consecutive denials; without it VGA priority is absolute.
//   clk_VGA : single clock, rising edge
//   reset   : asynchronous, active-high
//   bus     : vram_arbiter_if.slave (VGA, CPU and RAM signal groups)
//             vga_gnt, ram_* are combinational; vga_rvalid, cpu_ack are
//             registered; vga_rdata/cpu_rdata show RAM data on the return
//             cycle and otherwise hold their last returned value.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic           clk_VGA,
    input  logic           reset,
    vram_arbiter_if.slave  bus
);

    logic              force_cpu_c;
    logic              vga_win_c;
    logic              cpu_win_c;
    logic [ADDR_W-1:0] grant_addr_c;
    logic [DATA_W-1:0] grant_wdata_c;

    owner_t            rd_owner;
    logic              cpu_wr_q;
    logic              cpu_busy;
    logic              vga_rvalid_q;
    logic              cpu_ack_q;
    logic [DATA_W-1:0] vga_hold;
    logic [DATA_W-1:0] cpu_hold;

`ifdef VRAM_STARVE_GUARD_EN
    vram_starve_guard #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_guard (
        .clk         (clk_VGA),
        .rst         (reset),
        .cpu_req     (bus.cpu_req),
        .cpu_busy    (cpu_busy),
        .cpu_gnt     (cpu_win_c),
        .force_cpu_c (force_cpu_c)
    );
`else
    logic unused_starve_max;
    assign force_cpu_c       = 1'b0;
    assign unused_starve_max = |STARVE_W'(STARVE_MAX);
`endif

    // Grant decision: VGA first unless a CPU slot is forced; CPU only when not
    // in its ack cycle.
    always_comb begin
        vga_win_c     = bus.vga_req & ~force_cpu_c;
        cpu_win_c     = ~vga_win_c & bus.cpu_req & ~cpu_busy;
        grant_addr_c  = cpu_win_c ? bus.cpu_addr : bus.vga_addr;
        grant_wdata_c = cpu_win_c ? bus.cpu_wdata : DATA_W'(0);
    end

    // RAM command port.
    assign bus.vga_gnt   = vga_win_c;
    assign bus.ram_en    = vga_win_c | cpu_win_c;
    assign bus.ram_we    = cpu_win_c & bus.cpu_we;
    assign bus.ram_addr  = grant_addr_c;
    assign bus.ram_wdata = grant_wdata_c;

    // Return tracking: remembers who owns the data coming back next cycle.
    always_ff @(posedge clk_VGA or posedge reset) begin
        if (reset) begin
            rd_owner     <= OWN_NONE;
            cpu_wr_q     <= 1'b0;
            cpu_busy     <= 1'b0;
            vga_rvalid_q <= 1'b0;
            cpu_ack_q    <= 1'b0;
            vga_hold     <= '0;
            cpu_hold     <= '0;
        end else begin
            rd_owner     <= vga_win_c ? OWN_VGA : (cpu_win_c ? OWN_CPU : OWN_NONE);
            cpu_wr_q     <= cpu_win_c & bus.cpu_we;
            cpu_busy     <= cpu_win_c;
            vga_rvalid_q <= vga_win_c;
            cpu_ack_q    <= cpu_win_c;
            if (rd_owner == OWN_VGA) begin
                vga_hold <= bus.ram_rdata;
            end
            if ((rd_owner == OWN_CPU) && !cpu_wr_q) begin
                cpu_hold <= bus.ram_rdata;
            end
        end
    end

    // Return steering: live RAM data on the owner's return cycle, else held.
    assign bus.vga_rvalid = vga_rvalid_q;
    assign bus.cpu_ack    = cpu_ack_q;
    assign bus.vga_rdata  = (rd_owner == OWN_VGA) ? bus.ram_rdata : vga_hold;
    assign bus.cpu_rdata  = ((rd_owner == OWN_CPU) && !cpu_wr_q) ? bus.ram_rdata : cpu_hold;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: self-checking bench for vram_arbiter. A behavioural RAM
// answers the arbiter's RAM port; a cycle-level reference model (grant rule,
// sparse reference memory, starvation streak) predicts every output.
// Honours VRAM_STARVE_GUARD_EN the same way as the design.
module tb_vram_arbiter;
    import vram_pkg::*;

    localparam int unsigned AW   = DEF_ADDR_W;
    localparam int unsigned DW   = DEF_DATA_W;
    localparam int unsigned SMAX = DEF_STARVE_MAX;
`ifdef VRAM_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic clk_VGA = 1'b0;
    logic reset   = 1'b1;

    vram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    vram_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .STARVE_MAX (SMAX)
    ) dut (
        .clk_VGA (clk_VGA),
        .reset   (reset),
        .bus     (bus.slave)
    );

    always #5 clk_VGA = ~clk_VGA;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Deterministic power-up contents of the RAM.
    function automatic logic [DW-1:0] init_word(input int a);
        int unsigned h;
        h = (32'(a) * 32'd40503) ^ 32'h0000_5A5A;
        return DW'(h);
    endfunction

    // Behavioural single-port RAM, read data one cycle after the command.
    logic [DW-1:0] ram_mem [2**AW];
    bit            ram_wr  [2**AW];
    always @(posedge clk_VGA) begin
        if (bus.ram_en) begin
            if (bus.ram_we) begin
                ram_mem[bus.ram_addr] <= bus.ram_wdata;
                ram_wr[bus.ram_addr]  <= 1'b1;
            end else begin
                bus.ram_rdata <= ram_wr[bus.ram_addr] ? ram_mem[bus.ram_addr]
                                                      : init_word(int'(bus.ram_addr));
            end
        end
    end

    // Reference model state.
    logic [DW-1:0] ref_mem [int];
    int            m_prev_kind = 0;    // 0 none, 1 VGA read, 2 CPU read, 3 CPU write
    logic [DW-1:0] m_prev_data = '0;
    logic [DW-1:0] m_vga_hold  = '0;
    logic [DW-1:0] m_cpu_hold  = '0;
    bit            m_busy      = 1'b0;
    int            m_starve    = 0;
    int            ack_count   = 0;
    int            we_count    = 0;

    function automatic logic [DW-1:0] ref_read(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    // Per-cycle prediction and comparison, sampled mid-cycle.
    always @(negedge clk_VGA) begin : model
        bit            fv, gv, gc;
        logic [DW-1:0] ev, ec;
        if (reset) begin
            m_prev_kind = 0;
            m_vga_hold  = '0;
            m_cpu_hold  = '0;
            m_busy      = 1'b0;
            m_starve    = 0;
        end
        ev = (m_prev_kind == 1) ? m_prev_data : m_vga_hold;
        ec = (m_prev_kind == 2) ? m_prev_data : m_cpu_hold;
        check("vga_rvalid", 32'(bus.vga_rvalid), 32'(m_prev_kind == 1));
        check("vga_rdata",  32'(bus.vga_rdata),  32'(ev));
        check("cpu_ack",    32'(bus.cpu_ack),    32'(m_prev_kind >= 2));
        check("cpu_rdata",  32'(bus.cpu_rdata),  32'(ec));
        m_vga_hold = ev;
        m_cpu_hold = ec;
        if (bus.cpu_ack) ack_count++;
        if (bus.ram_we)  we_count++;

        fv = GUARD && bus.cpu_req && (m_starve == int'(SMAX));
        gv = bus.vga_req && !fv;
        gc = !gv && bus.cpu_req && !m_busy;
        check("vga_gnt",   32'(bus.vga_gnt),   32'(gv));
        check("ram_en",    32'(bus.ram_en),    32'(gv || gc));
        check("ram_we",    32'(bus.ram_we),    32'(gc && bus.cpu_we));
        check("ram_addr",  32'(bus.ram_addr),  gc ? 32'(bus.cpu_addr) : 32'(bus.vga_addr));
        check("ram_wdata", 32'(bus.ram_wdata), gc ? 32'(bus.cpu_wdata) : 32'd0);

        m_prev_kind = 0;
        if (gv) begin
            m_prev_kind = 1;
            m_prev_data = ref_read(int'(bus.vga_addr));
        end else if (gc) begin
            if (bus.cpu_we) begin
                ref_mem[int'(bus.cpu_addr)] = bus.cpu_wdata;
                m_prev_kind = 3;
            end else begin
                m_prev_kind = 2;
                m_prev_data = ref_read(int'(bus.cpu_addr));
            end
        end
        if (gc || !bus.cpu_req) m_starve = 0;
        else if (!m_busy && m_starve < int'(SMAX)) m_starve++;
        m_busy = gc;
        if (reset) begin
            m_prev_kind = 0;
            m_busy      = 1'b0;
            m_starve    = 0;
        end
    end

    task automatic tick();
        @(posedge clk_VGA);
        #1;
    endtask

    // Issue one CPU access and hold it until acknowledged (bounded wait).
    task automatic cpu_op(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input int max_wait, output int lat);
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = a;
        bus.cpu_wdata = d;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!bus.cpu_ack && lat < max_wait);
        check("cpu_ack_wait", 32'(bus.cpu_ack), 32'd1);
        bus.cpu_req = 1'b0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int lat, cnt, base, vga_pct;
        bus.vga_req   = 1'b0;
        bus.vga_addr  = '0;
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;

        // Reset, then idle.
        repeat (3) tick();
        reset = 1'b0;
        repeat (10) tick();
        check("idle_acks", 32'(ack_count), 32'd0);

        // CPU write then read back.
        base = we_count;
        cpu_op(1'b1, AW'(5), DW'(16'h1234), 50, lat);
        check("cpu_wr_lat", 32'(lat), 32'd1);
        tick();
        cpu_op(1'b0, AW'(5), '0, 50, lat);
        check("cpu_rd_lat", 32'(lat), 32'd1);
        check("cpu_rd_data", 32'(bus.cpu_rdata), 32'h1234);
        check("we_pulses", 32'(we_count - base), 32'd1);
        tick();

        // Simultaneous requests: VGA first, CPU right after VGA drops.
        bus.vga_req  = 1'b1;
        bus.vga_addr = AW'(7);
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = AW'(5);
        #1;
        check("simul_vga_gnt", 32'(bus.vga_gnt), 32'd1);
        repeat (3) tick();
        bus.vga_req = 1'b0;
        #1;
        check("cpu_after_vga", {29'd0, bus.ram_en, bus.ram_we, bus.vga_gnt}, 32'b100);
        check("cpu_after_vga_addr", 32'(bus.ram_addr), 32'd5);
        tick();
        check("cpu_after_vga_ack", 32'(bus.cpu_ack), 32'd1);
        check("cpu_after_vga_data", 32'(bus.cpu_rdata), 32'h1234);
        bus.cpu_req = 1'b0;
        tick();

        // 40-word VGA stream.
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            bus.vga_req  = 1'b1;
            bus.vga_addr = AW'(i);
            tick();
            if (bus.vga_rvalid) begin
                cnt++;
                check("stream_data", 32'(bus.vga_rdata), 32'(ref_read(i)));
            end
        end
        bus.vga_req = 1'b0;
        check("stream_rvalid_cnt", 32'(cnt), 32'd40);
        tick();
        check("stream_end", 32'(bus.vga_rvalid), 32'd0);

        // Starvation: continuous VGA with a pending CPU read.
        bus.vga_req  = 1'b1;
        bus.vga_addr = AW'(3);
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = AW'(5);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!bus.cpu_ack && lat < 100);
        if (GUARD) begin
            check("starve_lat", 32'(lat), 32'(SMAX + 1));
            bus.cpu_req = 1'b0;
            bus.vga_req = 1'b0;
        end else begin
            check("starve_no_ack", 32'(bus.cpu_ack), 32'd0);
            bus.vga_req = 1'b0;
            cpu_op(1'b0, AW'(5), '0, 10, lat);
            check("starve_release_lat", 32'(lat), 32'd1);
        end
        tick();

        // Reset in the cycle after a CPU read grant.
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = AW'(5);
        #1;
        check("pre_rst_gnt", {31'd0, bus.ram_en & ~bus.vga_gnt & ~bus.ram_we}, 32'd1);
        tick();
        reset       = 1'b1;
        bus.cpu_req = 1'b0;
        base        = ack_count;
        #1;
        check("rst_vga_rvalid", 32'(bus.vga_rvalid), 32'd0);
        check("rst_cpu_ack",    32'(bus.cpu_ack),    32'd0);
        check("rst_vga_rdata",  32'(bus.vga_rdata),  32'd0);
        check("rst_cpu_rdata",  32'(bus.cpu_rdata),  32'd0);
        repeat (2) tick();
        reset = 1'b0;
        repeat (3) tick();
        check("rst_no_ack", 32'(ack_count), 32'(base));

        // Randomized traffic with cancellations and occasional resets.
        for (int ph = 0; ph < 2; ph++) begin
            vga_pct = (ph == 0) ? 30 : 90;
            for (int c = 0; c < 1000; c++) begin
                tick();
                if (reset) reset = 1'b0;
                bus.vga_req  = ($urandom_range(0, 99) < vga_pct);
                bus.vga_addr = AW'($urandom_range(0, 31));
                if (bus.cpu_req) begin
                    if (bus.cpu_ack || $urandom_range(0, 49) == 0) bus.cpu_req = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    bus.cpu_req   = 1'b1;
                    bus.cpu_we    = $urandom_range(0, 1) == 1;
                    bus.cpu_addr  = AW'($urandom_range(0, 31));
                    bus.cpu_wdata = DW'($urandom);
                end
                if ($urandom_range(0, 299) == 0) begin
                    reset       = 1'b1;
                    bus.cpu_req = 1'b0;
                end
            end
        end
        reset       = 1'b0;
        bus.vga_req = 1'b0;
        bus.cpu_req = 1'b0;
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
